mips_trace_buffer: RTL

- Parametrised probe-capture block for the single-cycle MIPS core. It records CHANNELS datapath probes per cycle into a DEPTH-entry ring buffer: PC_out, ALU_out, ula_in1, ula_in2, d_mem_out.
- Capture stops a programmable number of samples after a compare-match trigger. The captured window then streams out oldest-first over a valid/ready handshake.
- Sits beside mips_top, in simulation or on-chip. It replaces ad-hoc waveform watching with a triggerable, self-contained trace.

---
 rtl/mips_trace_buffer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mips_trace_buffer.sv
// Triggerable probe-capture ring buffer for the single-cycle MIPS core.
// Records qualified probe samples, stops post_count samples after a trigger, then streams the window oldest-first.
module mips_trace_buffer #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 5,
  parameter int DEPTH    = 64,
  parameter int TRIG_CH  = 0,
  localparam int AW      = $clog2(DEPTH),
  localparam int DW      = CHANNELS * WIDTH
) (
  input  logic          clock,
  input  logic          reset_global,
  input  logic [DW-1:0] probe_in,
  input  logic          probe_valid,
  input  logic          arm,
  input  logic          abort,
  input  logic          trig_en,
  input  logic [WIDTH-1:0] trig_value,
  input  logic [AW-1:0] post_count,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_last,
  output logic [1:0]    state_o,
  output logic [AW:0]   fill_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } state_e;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic [AW-1:0] post_len_q, post_len_d;
  logic [AW-1:0] post_left_q, post_left_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   remain_q, remain_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic          wr_en;
  logic          trig_hit;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_ptr_nxt;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    post_len_d  = post_len_q;
    post_left_d = post_left_q;
    rd_ptr_d    = rd_ptr_q;
    remain_d    = remain_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_data_d   = rd_data_q;
    wr_en       = 1'b0;
    trig_hit    = probe_valid && trig_en && (probe_in[TRIG_CH*WIDTH +: WIDTH] == trig_value);
    // With fill==DEPTH the low bits wrap to zero, so the oldest entry is the next write slot.
    oldest      = wr_ptr_q - fill_q[AW-1:0];
    rd_ptr_nxt  = rd_ptr_q + AW'(1);

    if (abort) begin
      state_d    = IDLE;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      fill_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_d    = ARMED;
            wr_ptr_d   = '0;
            fill_d     = '0;
            post_len_d = post_count;
          end
        end
        ARMED, CAPTURE: begin
          if (probe_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_q != FULL) fill_d = fill_q + (AW+1)'(1);
            if (state_q == ARMED) begin
              if (trig_hit) begin
                if (post_len_q == '0) begin
                  state_d = READOUT;
                end else begin
                  state_d     = CAPTURE;
                  post_left_d = post_len_q;
                end
              end
            end else begin
              post_left_d = post_left_q - AW'(1);
              if (post_left_q == AW'(1)) state_d = READOUT;
            end
          end
        end
        READOUT: begin
          // The first READOUT cycle positions the read pointer and preloads the oldest entry.
          if (!rd_valid_q) begin
            rd_ptr_d   = oldest;
            remain_d   = fill_q;
            rd_data_d  = mem[oldest];
            rd_last_d  = (fill_q == (AW+1)'(1));
            rd_valid_d = 1'b1;
          end else if (rd_ready) begin
            if (rd_last_q) begin
              state_d    = IDLE;
              rd_valid_d = 1'b0;
              rd_last_d  = 1'b0;
              fill_d     = '0;
            end else begin
              rd_ptr_d  = rd_ptr_nxt;
              remain_d  = remain_q - (AW+1)'(1);
              rd_data_d = mem[rd_ptr_nxt];
              rd_last_d = (remain_q == (AW+1)'(2));
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset_global) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      post_len_q  <= '0;
      post_left_q <= '0;
      rd_ptr_q    <= '0;
      remain_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      post_len_q  <= post_len_d;
      post_left_q <= post_left_d;
      rd_ptr_q    <= rd_ptr_d;
      remain_q    <= remain_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= probe_in;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign state_o  = state_q;
  assign fill_o   = fill_q;

endmodule
